// File: rtl/aq_sequencer.sv
// aq_sequencer: operand latch, AQ/M registers, iteration counter and the
// IDLE/RUN/DONE control for the shift/add datapath. The per-step arithmetic
// lives in an external combinational stage fed through the st_* ports.
// Signed Booth multiply (op=00) and unsigned restoring divide (op=01) are
// accepted; op=1x and divide-by-zero are rejected with a one-cycle error.
module aq_sequencer #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [N-1:0]   data_a,
    input  logic [N-1:0]   data_b,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [N-1:0]   result_hi,
    output logic [N-1:0]   result_lo,
    output logic [N-1:0]   st_a,
    output logic [N:0]     st_q,
    output logic [N-1:0]   st_a_plus_m,
    output logic [N-1:0]   st_a_minus_m,
    output logic [2*N:0]   st_aq_reg,
    output logic           st_msb_AM,
    output logic           st_ov_count,
    output logic           st_msb_reg_A,
    output logic [1:0]     st_op,
    input  logic [2*N:0]   st_aq_out
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [2*N:0]    aq_r;
    logic [N-1:0]    m_r;
    logic [CW-1:0]   cnt_r;
    logic [1:0]      op_r;
    logic [N-1:0]    result_hi_r;
    logic [N-1:0]    result_lo_r;
    logic            done_r;
    logic            error_r;

    logic            load_s;
    logic            reject_s;
    logic            step_s;
    logic            finish_s;
    logic [2*N:0]    sh_s;

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s  = state_r;
        load_s   = 1'b0;
        reject_s = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if ((op == 2'b00) || ((op == 2'b01) && (data_a != {N{1'b0}}))) begin
                        load_s  = 1'b1;
                        state_s = S_RUN;
                    end else begin
                        reject_s = 1'b1;
                        state_s  = S_IDLE;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                step_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE: begin
                finish_s = 1'b1;
                state_s  = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Stage feed: divide presents AQ pre-shifted left; multiply presents it as is.
    always_comb begin
        sh_s = {aq_r[2*N-1:0], 1'b0};
        if (op_r == 2'b01) begin
            st_a        = sh_s[2*N:N+1];
            st_q        = sh_s[N:0];
            st_a_plus_m = sh_s[2*N:N+1];
        end else begin
            st_a        = aq_r[2*N:N+1];
            st_q        = aq_r[N:0];
            st_a_plus_m = aq_r[2*N:N+1] + m_r;
        end
        st_a_minus_m = st_a - m_r;
    end

    // State, datapath registers and registered status/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            aq_r        <= {(2*N+1){1'b0}};
            m_r         <= {N{1'b0}};
            cnt_r       <= {CW{1'b0}};
            op_r        <= 2'b00;
            result_hi_r <= {N{1'b0}};
            result_lo_r <= {N{1'b0}};
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= finish_s;
            error_r <= reject_s;
            if (load_s) begin
                aq_r  <= {{N{1'b0}}, data_b, 1'b0};
                m_r   <= data_a;
                cnt_r <= {CW{1'b0}};
                op_r  <= op;
            end else if (step_s) begin
                aq_r  <= st_aq_out;
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                aq_r  <= aq_r;
                cnt_r <= cnt_r;
            end
            // Both ops keep their answer in AQ[2N:1]: product, or {remainder, quotient}.
            if (finish_s) begin
                result_hi_r <= aq_r[2*N:N+1];
                result_lo_r <= aq_r[N:1];
            end else begin
                result_hi_r <= result_hi_r;
                result_lo_r <= result_lo_r;
            end
        end
    end

    assign busy         = (state_r != S_IDLE);
    assign done         = done_r;
    assign error        = error_r;
    assign result_hi    = result_hi_r;
    assign result_lo    = result_lo_r;
    assign st_aq_reg    = aq_r;
    assign st_op        = op_r;
    assign st_msb_AM    = 1'b0;
    assign st_ov_count  = 1'b0;
    assign st_msb_reg_A = 1'b0;

endmodule

// File: tb/tb_aq_sequencer.sv
// Testbench for aq_sequencer (N=4). Provides a behavioural operation stage
// and checks results against plain integer multiply / divide.
module tb_aq_sequencer;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [N-1:0]   data_a = '0;
    logic [N-1:0]   data_b = '0;
    logic           busy, done, error;
    logic [N-1:0]   result_hi, result_lo;
    logic [N-1:0]   st_a, st_a_plus_m, st_a_minus_m;
    logic [N:0]     st_q;
    logic [2*N:0]   st_aq_reg, st_aq_out;
    logic           st_msb_AM, st_ov_count, st_msb_reg_A;
    logic [1:0]     st_op;

    int errors = 0;
    int checks = 0;

    aq_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .data_a(data_a), .data_b(data_b),
        .busy(busy), .done(done), .error(error),
        .result_hi(result_hi), .result_lo(result_lo),
        .st_a(st_a), .st_q(st_q), .st_a_plus_m(st_a_plus_m),
        .st_a_minus_m(st_a_minus_m), .st_aq_reg(st_aq_reg),
        .st_msb_AM(st_msb_AM), .st_ov_count(st_ov_count),
        .st_msb_reg_A(st_msb_reg_A), .st_op(st_op), .st_aq_out(st_aq_out)
    );

    always #5 clk = ~clk;

    // Operation stage model: one Booth step (true sign kept) or one restoring-divide step.
    logic [N-1:0] stg_m;
    logic [N:0]   stg_ext;
    logic         stg_qbit;
    always_comb begin
        stg_m    = '0;
        stg_ext  = '0;
        stg_qbit = 1'b0;
        st_aq_out = '0;
        if (st_op == 2'b00) begin
            stg_m = st_a_plus_m - st_a;
            case (st_q[1:0])
                2'b01:   stg_ext = {st_a[N-1], st_a} + {stg_m[N-1], stg_m};
                2'b10:   stg_ext = {st_a[N-1], st_a} - {stg_m[N-1], stg_m};
                default: stg_ext = {st_a[N-1], st_a};
            endcase
            st_aq_out = {stg_ext, st_q[N:1]};
        end else begin
            stg_m    = st_a - st_a_minus_m;
            stg_qbit = (st_a >= stg_m);
            st_aq_out = {(stg_qbit ? st_a_minus_m : st_a_plus_m), st_q[N:2], stg_qbit, 1'b0};
        end
    end

    function automatic int sx(input logic [N-1:0] v);
        return v[N-1] ? int'(v) - (1 << N) : int'(v);
    endfunction

    function automatic logic [2*N-1:0] mult_ref(input logic [N-1:0] a, input logic [N-1:0] b);
        int p;
        p = sx(a) * sx(b);
        return p[2*N-1:0];
    endfunction

    function automatic logic [2*N-1:0] div_ref(input logic [N-1:0] a, input logic [N-1:0] b);
        int q, r;
        q = int'(b) / int'(a);
        r = int'(b) % int'(a);
        return {r[N-1:0], q[N-1:0]};
    endfunction

    // Issue one accepted operation; returns results, cycles to done (-1 on timeout)
    // and busy right after the accepting edge. Inputs are scrambled after acceptance.
    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [2*N-1:0] res, output int lat, output logic bsy);
        start = 1'b1; op = o; data_a = a; data_b = b;
        @(posedge clk); #1;
        bsy = busy;
        start = 1'b0; op = 2'($urandom); data_a = N'($urandom); data_b = N'($urandom);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        if (!done) lat = -1;
        res = {result_hi, result_lo};
    endtask

    logic [2*N-1:0] held;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, error, result_hi, result_lo, st_aq_reg, st_op} !== '0) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b err=%b res=%h aq=%h op=%b expected all 0",
                     busy, done, error, {result_hi, result_lo}, st_aq_reg, st_op);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, error, result_hi, result_lo} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b err=%b res=%h expected 0",
                     busy, done, error, {result_hi, result_lo});
        end
        held = '0;
    endtask

    task automatic test_mult();
        logic [N-1:0]   ta [3] = '{4'h3, 4'h8, 4'h7};
        logic [N-1:0]   tb [3] = '{4'hE, 4'h8, 4'h8};
        logic [2*N-1:0] te [3] = '{8'hFA, 8'h40, 8'hC8};
        logic [2*N-1:0] res;
        int lat;
        logic bsy;
        for (int i = 0; i < 3; i++) begin
            run_op(2'b00, ta[i], tb[i], res, lat, bsy);
            checks++;
            if (res !== te[i] || lat != N + 1 || bsy !== 1'b1) begin
                errors++;
                $display("FAIL mult_%0d: got res=%h lat=%0d busy=%b expected res=%h lat=%0d busy=1",
                         i, res, lat, bsy, te[i], N + 1);
            end
            held = te[i];
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || {result_hi, result_lo} !== held || busy !== 1'b0) begin
                errors++;
                $display("FAIL mult_hold_%0d: got done=%b res=%h busy=%b expected done=0 res=%h busy=0",
                         i, done, {result_hi, result_lo}, busy, held);
            end
        end
    endtask

    task automatic test_div();
        logic [N-1:0]   ta [2] = '{4'h2, 4'h3};
        logic [N-1:0]   tb [2] = '{4'h7, 4'h6};
        logic [2*N-1:0] te [2] = '{8'h13, 8'h02};
        logic [2*N-1:0] res;
        int lat;
        logic bsy;
        for (int i = 0; i < 2; i++) begin
            run_op(2'b01, ta[i], tb[i], res, lat, bsy);
            checks++;
            if (res !== te[i] || lat != N + 1 || bsy !== 1'b1) begin
                errors++;
                $display("FAIL div_%0d: got {rem,quo}=%h lat=%0d busy=%b expected %h lat=%0d busy=1",
                         i, res, lat, bsy, te[i], N + 1);
            end
            held = te[i];
        end
    endtask

    task automatic test_error();
        logic [1:0]   eo [3] = '{2'b01, 2'b10, 2'b11};
        logic [N-1:0] ea [3] = '{4'h0, 4'h3, 4'h5};
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; op = eo[i]; data_a = ea[i]; data_b = 4'h9;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL error_pulse_%0d: got err=%b busy=%b done=%b expected err=1 busy=0 done=0",
                         i, error, busy, done);
            end
            @(posedge clk); #1;
            checks++;
            if (error !== 1'b0 || busy !== 1'b0 || {result_hi, result_lo} !== held) begin
                errors++;
                $display("FAIL error_after_%0d: got err=%b busy=%b res=%h expected err=0 busy=0 res=%h",
                         i, error, busy, {result_hi, result_lo}, held);
            end
        end
    endtask

    task automatic test_start_mid_run();
        int lat;
        start = 1'b1; op = 2'b00; data_a = 4'h3; data_b = 4'hE;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; data_a = 4'h7; data_b = 4'h7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (lat < 20 && !done) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (done !== 1'b1 || lat != N + 1 || {result_hi, result_lo} !== 8'hFA) begin
            errors++;
            $display("FAIL start_mid_run: got done=%b lat=%0d res=%h expected done=1 lat=%0d res=fa",
                     done, lat, {result_hi, result_lo}, N + 1);
        end
        held = 8'hFA;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_mid_run_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [2*N-1:0] res;
        int lat;
        logic bsy;
        start = 1'b1; op = 2'b01; data_a = 4'h2; data_b = 4'h7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, error, result_hi, result_lo, st_aq_reg, st_op, st_a, st_q} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b err=%b res=%h aq=%h op=%b expected all 0",
                     busy, done, error, {result_hi, result_lo}, st_aq_reg, st_op);
        end
        held = '0;
        run_op(2'b01, 4'h3, 4'h6, res, lat, bsy);
        checks++;
        if (res !== 8'h02 || lat != N + 1) begin
            errors++;
            $display("FAIL after_reset_run: got res=%h lat=%0d expected 02 lat=%0d", res, lat, N + 1);
        end
        held = res;
    endtask

    // Back-to-back random operations; each new start lands in the previous done cycle.
    task automatic test_random();
        logic [2*N-1:0] res, exp_v;
        logic [N-1:0]   a, b;
        logic [1:0]     o;
        int lat;
        logic bsy;
        for (int i = 0; i < 40; i++) begin
            o = ($urandom_range(1, 0) == 0) ? 2'b00 : 2'b01;
            b = N'($urandom);
            if (o == 2'b00) begin
                a = N'($urandom);
                exp_v = mult_ref(a, b);
            end else begin
                a = N'($urandom_range((1 << (N - 1)) - 1, 1));
                exp_v = div_ref(a, b);
            end
            run_op(o, a, b, res, lat, bsy);
            checks++;
            if (res !== exp_v || lat != N + 1 || bsy !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d op=%b a=%h b=%h: got res=%h lat=%0d busy=%b expected res=%h lat=%0d",
                         i, o, a, b, res, lat, bsy, exp_v, N + 1);
            end
            held = exp_v;
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_error();
        test_start_mid_run();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
